// File: rtl/gear_shift_ctrl.sv
// Sequential gearbox shift controller: debounced paddles -> timed, exclusive up/down solenoid pulses + lockout.
// Latency: actuator rises DEBOUNCE_CYCLES+3 clocks after a stable press; presses while busy are rejected, never queued.
module gear_shift_ctrl #(
    parameter int NUM_GEARS            = 6,
    parameter int GEAR_W               = 4,
    parameter int CNT_W                = 32,
    parameter int DEBOUNCE_CYCLES      = 500000,
    parameter int UP_PULSE_CYCLES      = 5000000,
    parameter int DOWN_PULSE_CYCLES    = 5000000,
    parameter int NEUTRAL_PULSE_CYCLES = 2500000,
    parameter int LOCKOUT_CYCLES       = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 up_btn,
    input  logic                 down_btn,
    input  logic                 neutral_btn,
    output logic                 up_act,
    output logic                 down_act,
    output logic [GEAR_W-1:0]    gear,
    output logic [NUM_GEARS:0]   gear_led,
    output logic                 busy,
    output logic                 reject
);

    localparam int LED_W = NUM_GEARS + 1;
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0]  L_UP    = CNT_W'(UP_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  L_DN    = CNT_W'(DOWN_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  L_NT    = CNT_W'(NEUTRAL_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  L_LOCK  = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [GEAR_W-1:0] G_ONE   = GEAR_W'(1);
    localparam logic [GEAR_W-1:0] G_TOP   = GEAR_W'(NUM_GEARS);
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE_UP,
        S_PULSE_DOWN,
        S_PULSE_NEUTRAL,
        S_LOCKOUT
    } state_t;

    // Button lanes: bit 0 = up, bit 1 = down, bit 2 = neutral
    logic [2:0]      w_raw;
    logic [2:0]      r_sync1;
    logic [2:0]      r_sync2;
    logic [2:0]      r_db;
    logic [2:0]      r_db_q;
    logic [2:0]      r_press;
    logic [DB_W-1:0] r_db_cnt [3];

    assign w_raw = {neutral_btn, down_btn, up_btn};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_q  <= '0;
            r_press <= '0;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_db_q  <= r_db;
            r_press <= r_db & ~r_db_q;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    logic w_up_ev;
    logic w_dn_ev;
    logic w_nt_ev;
    logic w_any_ev;

    assign w_up_ev  = r_press[0];
    assign w_dn_ev  = r_press[1];
    assign w_nt_ev  = r_press[2];
    assign w_any_ev = |r_press;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [GEAR_W-1:0] r_gear;
    logic [GEAR_W-1:0] w_gear_nxt;
    logic [LED_W-1:0]  r_gear_led;
    logic              r_auto;
    logic              w_auto_nxt;
    logic              w_reject_nxt;
    logic              r_reject;
    logic              r_up_act;
    logic              r_down_act;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = (r_cnt != '0) ? r_cnt - CNT_W'(1) : '0;
        w_gear_nxt   = r_gear;
        w_auto_nxt   = r_auto;
        w_reject_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_up_ev && w_dn_ev) begin
                    w_reject_nxt = 1'b1;
                end else if (w_dn_ev) begin
                    if (r_gear == '0) begin
                        w_state_nxt = S_PULSE_DOWN;
                        w_gear_nxt  = G_ONE;
                        w_cnt_nxt   = L_DN;
                    end else if (r_gear > G_ONE) begin
                        w_state_nxt = S_PULSE_DOWN;
                        w_gear_nxt  = r_gear - G_ONE;
                        w_cnt_nxt   = L_DN;
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                end else if (w_up_ev) begin
                    if (r_gear != '0 && r_gear < G_TOP) begin
                        w_state_nxt = S_PULSE_UP;
                        w_gear_nxt  = r_gear + G_ONE;
                        w_cnt_nxt   = L_UP;
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                end else if (w_nt_ev) begin
                    if (r_gear == G_ONE) begin
                        w_state_nxt = S_PULSE_NEUTRAL;
                        w_gear_nxt  = '0;
                        w_cnt_nxt   = L_NT;
                    end else if (r_gear != '0) begin
                        w_auto_nxt  = 1'b1;
                        w_state_nxt = S_PULSE_DOWN;
                        w_gear_nxt  = r_gear - G_ONE;
                        w_cnt_nxt   = L_DN;
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                end
            end
            S_PULSE_UP, S_PULSE_DOWN, S_PULSE_NEUTRAL: begin
                w_reject_nxt = w_any_ev;
                if (w_up_ev || w_dn_ev) begin
                    w_auto_nxt = 1'b0;
                end
                if (r_cnt == '0) begin
                    w_state_nxt = S_LOCKOUT;
                    w_cnt_nxt   = L_LOCK;
                end
            end
            S_LOCKOUT: begin
                w_reject_nxt = w_any_ev;
                // An abort press landing on the final lockout cycle still cancels the step-down
                if (w_up_ev || w_dn_ev) begin
                    w_auto_nxt = 1'b0;
                end
                if (r_cnt == '0) begin
                    if (w_auto_nxt && r_gear > G_ONE) begin
                        w_state_nxt = S_PULSE_DOWN;
                        w_gear_nxt  = r_gear - G_ONE;
                        w_cnt_nxt   = L_DN;
                    end else if (w_auto_nxt && r_gear == G_ONE) begin
                        w_state_nxt = S_PULSE_NEUTRAL;
                        w_gear_nxt  = '0;
                        w_auto_nxt  = 1'b0;
                        w_cnt_nxt   = L_NT;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_gear     <= '0;
            r_gear_led <= LED_W'(1);
            r_auto     <= 1'b0;
            r_reject   <= 1'b0;
            r_up_act   <= 1'b0;
            r_down_act <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_gear     <= w_gear_nxt;
            r_gear_led <= LED_W'(1) << w_gear_nxt;
            r_auto     <= w_auto_nxt;
            r_reject   <= w_reject_nxt;
            r_up_act   <= (w_state_nxt == S_PULSE_UP) || (w_state_nxt == S_PULSE_NEUTRAL);
            r_down_act <= (w_state_nxt == S_PULSE_DOWN);
        end
    end

    assign up_act   = r_up_act;
    assign down_act = r_down_act;
    assign gear     = r_gear;
    assign gear_led = r_gear_led;
    assign busy     = (r_state != S_IDLE);
    assign reject   = r_reject;

endmodule

// File: doc/gear_shift_ctrl.md
Name: gear_shift_ctrl

Overview:
Parametrised sequential-gearbox shift controller for the paddle-shift FPGA. It synchronises and debounces the up, down and neutral buttons and tracks the current gear (0 = neutral, 1..NUM_GEARS). It drives timed, mutually exclusive up/down actuator pulses with a post-shift lockout, and can step automatically from any gear down to neutral. It sits between the steering-wheel button inputs and the solenoid drivers, and also feeds the dash gear LEDs.

Parameters:
NUM_GEARS, 6, highest forward gear (2..14)
GEAR_W, 4, width of gear output; must hold NUM_GEARS
CNT_W, 32, width of the shared timing counter
DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a button level
UP_PULSE_CYCLES, 5000000, up-actuator on-time for a full upshift
DOWN_PULSE_CYCLES, 5000000, down-actuator on-time for a full downshift
NEUTRAL_PULSE_CYCLES, 2500000, up-actuator on-time for the half-travel shift from 1 to N
LOCKOUT_CYCLES, 1000000, dead time after every pulse before the next shift is accepted

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
up_btn  in  1  raw up paddle, asynchronous, active-high
down_btn  in  1  raw down paddle, asynchronous, active-high
neutral_btn  in  1  raw neutral button, asynchronous, active-high
up_act  out  1  up solenoid drive
down_act  out  1  down solenoid drive
gear  out  GEAR_W  current gear, 0 = neutral
gear_led  out  NUM_GEARS+1  one-hot gear indicator; bit g set when gear == g
busy  out  1  high in every state other than IDLE
reject  out  1  one-cycle pulse when a debounced press is ignored

Behaviour:
- Reset (async assert, sync release): gear=0, gear_led=1, up_act=0, down_act=0, busy=0, reject=0, FSM=IDLE, debounced levels=0, counters=0, auto_neutral=0.
- Input path: each button uses a 2-flop synchroniser and then a debounce counter. The debounced level takes the synchronised value after it has differed from the debounced level for DEBOUNCE_CYCLES consecutive clocks. A press event is the debounced level going 0->1, and lasts one cycle.
- Latency: the actuator asserts exactly DEBOUNCE_CYCLES+3 clocks after the first clk edge at which a stable raw press is sampled.
- FSM states: IDLE, PULSE_UP, PULSE_DOWN, PULSE_NEUTRAL, LOCKOUT.
- IDLE, with priority down > up > neutral for single events:
  - up press with 1 <= gear < NUM_GEARS -> PULSE_UP; gear+1.
  - down press with gear >= 2 -> PULSE_DOWN; gear-1.
  - down press with gear == 0 -> PULSE_DOWN; gear=1.
  - neutral press with gear == 1 -> PULSE_NEUTRAL; gear=0.
  - neutral press with gear >= 2 -> set auto_neutral; PULSE_DOWN; gear-1.
- gear updates in the same cycle the pulse starts.
- PULSE_UP and PULSE_NEUTRAL drive up_act only. PULSE_DOWN drives down_act only. Each holds for exactly its pulse-cycle count, then goes to LOCKOUT. up_act and down_act are never high together.
- LOCKOUT lasts LOCKOUT_CYCLES with both actuators low, then:
  - if auto_neutral is set and gear >= 2 -> PULSE_DOWN; gear-1.
  - if auto_neutral is set and gear == 1 -> PULSE_NEUTRAL; gear=0; clear auto_neutral.
  - otherwise -> IDLE.
- Auto-neutral abort: any up or down press while auto_neutral is set clears it. The pulse in progress still completes, and the aborting press itself is rejected.
- Rejected (reject=1, no state change):
  - press events arriving in any non-IDLE state (they are not queued);
  - up at gear 0 or at NUM_GEARS;
  - down at gear 1;
  - neutral at gear 0;
  - up and down press events in the same cycle (both rejected; a neutral event in that cycle is also rejected).
- gear_led is registered from the gear next-state, so it changes in the same cycle as gear.
- Counter: a single CNT_W down-counter is loaded on each state entry and the state exits when it reaches 0. A 0-cycle parameter is not legal.
- Reset asserted mid-pulse forces both actuators low immediately and gear to 0.

Test Plan (sim params: DEBOUNCE=4, UP=20, DOWN=20, NEUTRAL=10, LOCKOUT=8, NUM_GEARS=6):
1. Reset, then a down press at N -> down_act high exactly 20 cycles starting 7 cycles after the press is sampled; gear=1; gear_led=0b0000010; busy low again 28 cycles after the pulse starts.
2. From gear 1, 5 spaced up presses -> gear reaches 6. A 6th up press gives reject=1, gear stays 6, and no actuator activity.
3. Up press held only 3 cycles (a glitch) -> no press event and no actuator activity. A down press arriving during PULSE_UP -> reject pulse; only the up shift occurs.
4. At gear 4, neutral press -> 3 down pulses of 20 cycles, each separated by 8 idle cycles, then one 10-cycle up_act pulse. Final gear=0, gear_led=1, auto_neutral cleared.
5. Same start as test 4, with an up press during the second down pulse -> that pulse finishes, gear=2, FSM goes to IDLE after lockout, reject pulsed.
6. rst_n dropped mid-PULSE_UP at gear 3 -> up_act=0 asynchronously and gear=0. Up and down pressed in the same cycle -> reject, no shift.
